rotate_seq: RTL and testbench



---
 rtl/rotate_pkg.sv | 18 +
 rtl/barrelShift32.sv | 23 ++
 rtl/rotate_seq.sv | 132 +++++++++++++
 tb/tb_rotate_seq.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/rotate_pkg.sv
// Shared types and constants for the iterative rotate sequencer.
// State encoding, datapath widths and rotate direction codes.
package rotate_pkg;

    localparam int DATA_W = 32;
    localparam int MOVE_W = 5;
    localparam int REP_W  = 4;

    localparam logic ROT_LEFT  = 1'b0;
    localparam logic ROT_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_e;

endpackage

// File: rtl/barrelShift32.sv
// 32-bit combinational rotator: direction 1 rotates right, 0 rotates left.
// Rotation is built from two opposite shifts OR-ed together.
module barrelShift32 (
    input  logic [31:0] sample,
    input  logic [4:0]  move,
    input  logic        direction,
    output logic [31:0] result
);

    logic [5:0] back;

    // a 32-bit shift for move==0 yields zero, so the OR stays correct
    assign back = 6'd32 - {1'b0, move};

    always_comb begin
        result = '0;
        if (direction)
            result = (sample >> move) | (sample << back);
        else
            result = (sample << move) | (sample >> back);
    end

endmodule

// File: rtl/rotate_seq.sv
// Iterative rotate sequencer: applies a rotation reps times, one per clock.
// Optional RUN-cycle and result counters under ROTATE_SEQ_CYCCNT_EN.
module rotate_seq
    import rotate_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DATA_W-1:0] cmd_sample,
    input  logic [MOVE_W-1:0] cmd_move,
    input  logic              cmd_direction,
    input  logic [REP_W-1:0]  cmd_reps,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              busy
`ifdef ROTATE_SEQ_CYCCNT_EN
    ,
    output logic [15:0]       cyc_cnt,
    output logic [15:0]       cmd_cnt
`endif
);

    seq_state_e        state_q;
    seq_state_e        state_d;
    logic [DATA_W-1:0] acc;
    logic [MOVE_W-1:0] move_q;
    logic              dir_q;
    logic [REP_W-1:0]  remain;
    logic [DATA_W-1:0] rot;
    logic              last_step;

    barrelShift32 u_rot (
        .sample    (acc),
        .move      (move_q),
        .direction (dir_q),
        .result    (rot)
    );

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign last_step = (remain == REP_W'(1));

    always_ff @(posedge clk) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid)
                    state_d = (cmd_reps == '0) ? DONE : RUN;
            end
            RUN: begin
                if (last_step)
                    state_d = DONE;
            end
            DONE: begin
                if (res_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // result registers load only on entry to DONE so acc never leaks out
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc       <= '0;
            move_q    <= '0;
            dir_q     <= ROT_LEFT;
            remain    <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        acc    <= cmd_sample;
                        move_q <= cmd_move;
                        dir_q  <= cmd_direction;
                        remain <= cmd_reps;
                        if (cmd_reps == '0) begin
                            res_valid <= 1'b1;
                            res_data  <= cmd_sample;
                        end
                    end
                end
                RUN: begin
                    acc    <= rot;
                    remain <= remain - REP_W'(1);
                    if (last_step) begin
                        res_valid <= 1'b1;
                        res_data  <= rot;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        res_data  <= '0;
                    end
                end
                default: begin
                    res_valid <= 1'b0;
                    res_data  <= '0;
                end
            endcase
        end
    end

`ifdef ROTATE_SEQ_CYCCNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cyc_cnt <= '0;
            cmd_cnt <= '0;
        end else begin
            if (state_q == RUN && cyc_cnt != 16'hFFFF)
                cyc_cnt <= cyc_cnt + 16'd1;
            if (res_valid && res_ready)
                cmd_cnt <= cmd_cnt + 16'd1;
        end
    end
`else
    // core-only build: no counters
`endif

endmodule

// File: tb/tb_rotate_seq.sv
// Self-checking bench for rotate_seq: directed cases plus random commands
// checked against a bit-index rotation model.
module tb_rotate_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_sample;
    logic [4:0]  cmd_move;
    logic        cmd_direction;
    logic [3:0]  cmd_reps;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic        busy;
`ifdef ROTATE_SEQ_CYCCNT_EN
    logic [15:0] cyc_cnt;
    logic [15:0] cmd_cnt;
    int          exp_cyc;
    int          exp_cmd;
`endif

    int vectors = 0;
    int miscompares = 0;

    rotate_seq dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_sample    (cmd_sample),
        .cmd_move      (cmd_move),
        .cmd_direction (cmd_direction),
        .cmd_reps      (cmd_reps),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_data      (res_data),
        .busy          (busy)
`ifdef ROTATE_SEQ_CYCCNT_EN
        ,
        .cyc_cnt       (cyc_cnt),
        .cmd_cnt       (cmd_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [31:0] x,
                                          input int move, input int reps,
                                          input logic right);
        logic [31:0] o;
        int amt;
        amt = (move * reps) % 32;
        o = '0;
        for (int i = 0; i < 32; i++) begin
            if (right) o[i] = x[(i + amt) % 32];
            else       o[(i + amt) % 32] = x[i];
        end
        return o;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic junk_cmd;
        cmd_valid     = 1'b1;
        cmd_sample    = $urandom;
        cmd_move      = 5'($urandom);
        cmd_direction = 1'($urandom);
        cmd_reps      = 4'($urandom);
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
`ifdef ROTATE_SEQ_CYCCNT_EN
        exp_cyc = 0;
        exp_cmd = 0;
`endif
    endtask

    task automatic run_cmd(input logic [31:0] s, input logic [4:0] m,
                           input logic d, input logic [3:0] r,
                           input int hold);
        logic [31:0] exp;
        exp = model(s, int'(m), int'(r), d);
        chk("idle_ready", 32'(cmd_ready), 32'd1);
        chk("idle_busy", 32'(busy), 32'd0);
        cmd_valid = 1'b1;
        cmd_sample = s;
        cmd_move = m;
        cmd_direction = d;
        cmd_reps = r;
        step();
        for (int k = 0; k < int'(r); k++) begin
            chk("run_valid", 32'(res_valid), 32'd0);
            chk("run_data", res_data, 32'd0);
            chk("run_busy", 32'(busy), 32'd1);
            chk("run_ready", 32'(cmd_ready), 32'd0);
            junk_cmd();
            step();
        end
        cmd_valid = 1'b0;
        chk("done_valid", 32'(res_valid), 32'd1);
        chk("done_data", res_data, exp);
        chk("done_busy", 32'(busy), 32'd1);
        for (int k = 0; k < hold; k++) begin
            junk_cmd();
            step();
            chk("hold_valid", 32'(res_valid), 32'd1);
            chk("hold_data", res_data, exp);
            chk("hold_ready", 32'(cmd_ready), 32'd0);
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk("ret_valid", 32'(res_valid), 32'd0);
        chk("ret_data", res_data, 32'd0);
        chk("ret_ready", 32'(cmd_ready), 32'd1);
`ifdef ROTATE_SEQ_CYCCNT_EN
        exp_cyc += int'(r);
        exp_cmd += 1;
        chk("cyc_cnt", 32'(cyc_cnt), 32'(exp_cyc));
        chk("cmd_cnt", 32'(cmd_cnt), 32'(exp_cmd));
`endif
    endtask

    initial begin
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_sample = '0;
        cmd_move = '0;
        cmd_direction = 1'b0;
        cmd_reps = '0;
        res_ready = 1'b0;
        step();
        junk_cmd();
        step();
        cmd_valid = 1'b0;
        rst_n = 1'b1;
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(res_valid), 32'd0);
        chk("rst_data", res_data, 32'd0);
`ifdef ROTATE_SEQ_CYCCNT_EN
        exp_cyc = 0;
        exp_cmd = 0;
`endif

        run_cmd(32'h8000_0001, 5'd1, 1'b1, 4'd1, 0);
        chk("known_ror1", model(32'h8000_0001, 1, 1, 1'b1), 32'hC000_0000);
        run_cmd(32'h1234_5678, 5'd8, 1'b0, 4'd4, 0);
        run_cmd(32'h0000_0001, 5'd5, 1'b1, 4'd3, 0);
        chk("known_ror15", model(32'h0000_0001, 5, 3, 1'b1), 32'h0002_0000);
        run_cmd(32'hDEAD_BEEF, 5'd7, 1'b0, 4'd0, 5);
        run_cmd(32'hA5A5_0F0F, 5'd0, 1'b1, 4'd15, 1);
        run_cmd(32'h0F00_00F1, 5'd31, 1'b0, 4'd2, 0);

        // abort a long command on its third RUN cycle
        cmd_valid = 1'b1;
        cmd_sample = 32'hCAFE_F00D;
        cmd_move = 5'd3;
        cmd_direction = 1'b0;
        cmd_reps = 4'd10;
        step();
        cmd_valid = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
`ifdef ROTATE_SEQ_CYCCNT_EN
        exp_cyc = 0;
        exp_cmd = 0;
`endif
        chk("abort_ready", 32'(cmd_ready), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_valid", 32'(res_valid), 32'd0);
        chk("abort_data", res_data, 32'd0);
        for (int k = 0; k < 12; k++) begin
            step();
            chk("abort_quiet", 32'(res_valid), 32'd0);
        end

        run_cmd(32'h1357_9BDF, 5'd2, 1'b1, 4'd3, 0);
        run_cmd(32'h2468_ACE0, 5'd9, 1'b0, 4'd4, 0);

        do_reset();
        for (int n = 0; n < 40; n++) begin
            run_cmd($urandom, 5'($urandom), 1'($urandom), 4'($urandom),
                    int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
